mdc_delay_commutator: RTL and testbench
=======================================

Name: mdc_delay_commutator

Overview:
- Registered radix-2 MDC delay-commutator for the 32-point FFT datapath.
- Upper lane passes through a DEPTH-sample delay line, then a 2x2 swap switch, then a DEPTH-sample delay line on the lower lane.
- Pairs samples DEPTH apart onto the same beat for the next butterfly.
- Parametrised in width and depth; stall-able via in_valid; has frame sync and a bypass mode (pure aligned delay).

Parameters:
- WIDTH, 9: signed bit width of each re/im component.
- DEPTH, 8: delay-line depth in valid samples; power of two, 1..16; switch period is 2*DEPTH samples.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat qualifier; all state advances only on beats.
- frame_start  in  1  sampled with in_valid; this beat is treated as sample index k=0.
- mode  in  1  0 = commutate, 1 = bypass (switch forced straight); sampled every beat.
- in_up_re, in_up_im  in  WIDTH  upper-lane sample, signed.
- in_low_re, in_low_im  in  WIDTH  lower-lane sample, signed.
- out_valid  out  1  output beat qualifier, registered.
- out_up_re, out_up_im  out  WIDTH  upper output, registered.
- out_low_re, out_low_im  out  WIDTH  lower output, registered.

Behaviour:
- Reset (async assert, sync release): all outputs 0, out_valid 0, counter k 0, fill count 0, both delay lines cleared to 0.
- Beat = clock edge with in_valid=1. Non-beat cycles: all state and outputs hold, out_valid drops to 0.
- Sample counter k: log2(2*DEPTH) bits, wraps modulo 2*DEPTH.
  - On a beat with frame_start=1, the beat uses k=0 and the counter becomes 1.
  - Otherwise the beat uses the current k and the counter becomes k+1.
- Select: sel = bit log2(DEPTH) of k (for DEPTH=1, bit 0), forced to 0 when mode=1.
- Per beat, with a(k) / b(k) the upper / lower input:
  - x0 = D1 output (a delayed DEPTH beats); x1 = b(k).
  - sel=0: y0=x0, y1=x1. sel=1: y0=x1, y1=x0.
  - D1 shifts in a(k). D2 shifts in y1.
  - out_up <= y0; out_low <= D2 output (y1 from DEPTH beats earlier).
- Latency: DEPTH beats plus one register cycle. No arithmetic, so widths are unchanged.
- Fill count saturates at DEPTH and is not cleared by frame_start.
  - out_valid <= 1 on a beat only when fill count == DEPTH before that beat; the first DEPTH beats after reset produce out_valid=0.
- A mode change takes effect on the next beat. Data already inside D2 is not re-steered.
- frame_start mid-frame realigns the counter immediately; delay-line contents are kept.
- in_valid=0 mid-frame freezes everything; the sequence resumes identically, so gaps are invisible apart from timing.

Decomposition:
- Shared package fft_mdc_pkg:
  - default WIDTH;
  - cplx_t packed type {re, im};
  - function clog2 for the counter width.
- One sub-module, mdc_delay_line: parameters DEPTH and W; ports clk, rst_n, en, din, dout; shift-register delay; instantiated twice at W = 2*WIDTH.

Test Plan:
- DEPTH=2, mode=0, frame_start on first beat, upper a0..a7 = 1..8, lower b0..b7 = 11..18, continuous valid.
  - Output beats k=2..7 give (up, low): (13,11) (14,12) (3,1) (4,2) (17,15) (18,16).
  - out_valid stays 0 for the k=0,1 beats.
- Same stimulus with mode=1 → outputs from k=2: (1,11) (2,12) (3,13) (4,14) (5,15) (6,16).
- Same as the first test with in_valid deasserted for 3 cycles after k=3.
  - Identical output sequence; out_valid=0 and outputs held during the gap.
- Async reset (rst_n low) pulsed between clock edges at k=5.
  - All outputs and out_valid are 0 immediately.
  - After release, the first valid output appears after DEPTH fresh beats.
- DEPTH=8, WIDTH=9: inputs -256 and +255 on lanes.
  - Sign is preserved through both delay lines.
  - Swap period is 16 beats; the counter wraps to 0 correctly with no frame_start.
- frame_start reasserted at k=3 (DEPTH=2): next beats use sel=0 for two beats, then sel=1, per the realigned index.

Source files
------------

// File: rtl/fft_mdc_pkg.sv
// rtl/fft_mdc_pkg.sv - shared types and helpers for the MDC FFT datapath
package fft_mdc_pkg;

    localparam int DEFAULT_WIDTH = 9;

    typedef struct packed {
        logic signed [DEFAULT_WIDTH-1:0] re;
        logic signed [DEFAULT_WIDTH-1:0] im;
    } cplx_t;

    // Ceiling log2; clog2(1) is 0 so callers size single-entry counters themselves
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mdc_delay_line.sv
// rtl/mdc_delay_line.sv - enable-gated shift-register delay of DEPTH beats
module mdc_delay_line #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] taps [DEPTH];

    // Shift one stage per beat; reset clears every stage so the line starts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/mdc_delay_commutator.sv
// rtl/mdc_delay_commutator.sv - radix-2 MDC delay-commutator with bypass and frame sync
module mdc_delay_commutator
    import fft_mdc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             frame_start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_up_re,
    input  logic [WIDTH-1:0] in_up_im,
    input  logic [WIDTH-1:0] in_low_re,
    input  logic [WIDTH-1:0] in_low_im,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_up_re,
    output logic [WIDTH-1:0] out_up_im,
    output logic [WIDTH-1:0] out_low_re,
    output logic [WIDTH-1:0] out_low_im
);

    // Counter spans one switch period (2*DEPTH); the select is its top bit
    localparam int KW      = clog2(2 * DEPTH);
    localparam int SEL_BIT = clog2(DEPTH);
    localparam int FW      = clog2(DEPTH + 1);
    localparam int LW      = 2 * WIDTH;

    logic [KW-1:0] k_q;
    logic [KW-1:0] k_use;
    logic [FW-1:0] fill_q;
    logic          sel;
    logic [LW-1:0] x0;
    logic [LW-1:0] x1;
    logic [LW-1:0] y0;
    logic [LW-1:0] y1;
    logic [LW-1:0] d2_out;

    // Upper lane delayed DEPTH beats ahead of the switch
    mdc_delay_line #(
        .DEPTH (DEPTH),
        .W     (LW)
    ) u_d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   ({in_up_re, in_up_im}),
        .dout  (x0)
    );

    // Lower switch output delayed DEPTH beats to re-align the pair
    mdc_delay_line #(
        .DEPTH (DEPTH),
        .W     (LW)
    ) u_d2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (y1),
        .dout  (d2_out)
    );

    // Beat index (frame_start forces 0 on this beat) and the 2x2 switch
    always_comb begin
        k_use = frame_start ? '0 : k_q;
        sel   = k_use[SEL_BIT] & ~mode;
        x1    = {in_low_re, in_low_im};
        y0    = x0;
        y1    = x1;
        if (sel) begin
            y0 = x1;
            y1 = x0;
        end
    end

    // Sample counter and saturating fill count; both move only on beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            fill_q <= '0;
        end else if (in_valid) begin
            k_q <= k_use + KW'(1);
            if (fill_q != FW'(DEPTH)) begin
                fill_q <= fill_q + FW'(1);
            end
        end
    end

    // Output registers hold between beats; valid pulses only on filled beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_up_re  <= '0;
            out_up_im  <= '0;
            out_low_re <= '0;
            out_low_im <= '0;
        end else if (in_valid) begin
            out_valid  <= (fill_q == FW'(DEPTH));
            out_up_re  <= y0[LW-1:WIDTH];
            out_up_im  <= y0[WIDTH-1:0];
            out_low_re <= d2_out[LW-1:WIDTH];
            out_low_im <= d2_out[WIDTH-1:0];
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// tb/tb_mdc_delay_commutator.sv - scoreboard bench for mdc_delay_commutator
module tb_mdc_delay_commutator;
    import fft_mdc_pkg::*;

    localparam int W = 9;

    typedef struct packed {
        cplx_t up;
        cplx_t low;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vld2 = 1'b0;
    logic vld8 = 1'b0;
    logic fs = 1'b0;
    logic mode = 1'b0;
    logic [W-1:0] up_re = '0;
    logic [W-1:0] up_im = '0;
    logic [W-1:0] low_re = '0;
    logic [W-1:0] low_im = '0;

    logic         ov2;
    logic [W-1:0] o2_ur, o2_ui, o2_lr, o2_li;
    logic         ov8;
    logic [W-1:0] o8_ur, o8_ui, o8_lr, o8_li;

    exp_t q2[$];
    exp_t q8[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdc_delay_commutator #(.WIDTH(W), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld2), .frame_start(fs), .mode(mode),
        .in_up_re(up_re), .in_up_im(up_im), .in_low_re(low_re), .in_low_im(low_im),
        .out_valid(ov2), .out_up_re(o2_ur), .out_up_im(o2_ui),
        .out_low_re(o2_lr), .out_low_im(o2_li)
    );

    mdc_delay_commutator #(.WIDTH(W), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld8), .frame_start(fs), .mode(mode),
        .in_up_re(up_re), .in_up_im(up_im), .in_low_re(low_re), .in_low_im(low_im),
        .out_valid(ov8), .out_up_re(o8_ur), .out_up_im(o8_ui),
        .out_low_re(o8_lr), .out_low_im(o8_li)
    );

    function automatic exp_t mk(input int u, input int l);
        exp_t e;
        e.up.re  = u[W-1:0];
        e.up.im  = ~u[W-1:0];
        e.low.re = l[W-1:0];
        e.low.im = ~l[W-1:0];
        return e;
    endfunction

    // Scoreboard pop for the DEPTH=2 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov2) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL d2_unexpected_valid got=%h required=none", {o2_ur, o2_ui, o2_lr, o2_li});
            end else begin
                e = q2.pop_front();
                if ({o2_ur, o2_ui, o2_lr, o2_li} !== e) begin
                    failures++;
                    $display("FAIL d2_output got=%h required=%h", {o2_ur, o2_ui, o2_lr, o2_li}, e);
                end
            end
        end
    end

    // Scoreboard pop for the DEPTH=8 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov8) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL d8_unexpected_valid got=%h required=none", {o8_ur, o8_ui, o8_lr, o8_li});
            end else begin
                e = q8.pop_front();
                if ({o8_ur, o8_ui, o8_lr, o8_li} !== e) begin
                    failures++;
                    $display("FAIL d8_output got=%h required=%h", {o8_ur, o8_ui, o8_lr, o8_li}, e);
                end
            end
        end
    end

    task automatic drive(input bit to8, input int a, input int b, input bit f);
        up_re  = a[W-1:0];
        up_im  = ~a[W-1:0];
        low_re = b[W-1:0];
        low_im = ~b[W-1:0];
        fs     = f;
        if (to8) vld8 = 1'b1;
        else     vld2 = 1'b1;
        @(posedge clk);
        #1;
        vld2 = 1'b0;
        vld8 = 1'b0;
        fs   = 1'b0;
    endtask

    task automatic do_reset();
        vld2  = 1'b0;
        vld8  = 1'b0;
        fs    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ov2, o2_ur, o2_ui, o2_lr, o2_li} !== '0) begin
            failures++;
            $display("FAIL reset_d2 got=%h required=0", {ov2, o2_ur, o2_ui, o2_lr, o2_li});
        end
        checks++;
        if ({ov8, o8_ur, o8_ui, o8_lr, o8_li} !== '0) begin
            failures++;
            $display("FAIL reset_d8 got=%h required=0", {ov8, o8_ur, o8_ui, o8_lr, o8_li});
        end
        do_reset();
    endtask

    task automatic test_commutate();
        int eu[6] = '{13, 14, 3, 4, 17, 18};
        int el[6] = '{11, 12, 1, 2, 15, 16};
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n >= 2) q2.push_back(mk(eu[n-2], el[n-2]));
            drive(1'b0, n + 1, n + 11, n == 0);
            if (n < 2) begin
                checks++;
                if (ov2 !== 1'b0) begin
                    failures++;
                    $display("FAIL commutate_fill_valid beat=%0d got=%b required=0", n, ov2);
                end
            end
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL commutate_drain got=%0d required=0", q2.size());
        end
    endtask

    task automatic test_bypass();
        do_reset();
        mode = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (n >= 2) q2.push_back(mk(n - 1, n + 9));
            drive(1'b0, n + 1, n + 11, n == 0);
        end
        repeat (2) @(posedge clk);
        mode = 1'b0;
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL bypass_drain got=%0d required=0", q2.size());
        end
    endtask

    task automatic test_gap();
        int eu[6] = '{13, 14, 3, 4, 17, 18};
        int el[6] = '{11, 12, 1, 2, 15, 16};
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n >= 2) q2.push_back(mk(eu[n-2], el[n-2]));
            drive(1'b0, n + 1, n + 11, n == 0);
            if (n == 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (ov2 !== 1'b0 || {o2_ur, o2_ui, o2_lr, o2_li} !== mk(14, 12)) begin
                        failures++;
                        $display("FAIL gap_hold cycle=%0d got=%b/%h required=0/%h",
                                 g, ov2, {o2_ur, o2_ui, o2_lr, o2_li}, mk(14, 12));
                    end
                end
            end
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL gap_drain got=%0d required=0", q2.size());
        end
    endtask

    task automatic test_async_reset();
        int eu[6] = '{13, 14, 3, 4, 17, 18};
        int el[6] = '{11, 12, 1, 2, 15, 16};
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n >= 2) q2.push_back(mk(eu[n-2], el[n-2]));
            drive(1'b0, n + 1, n + 11, n == 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov2, o2_ur, o2_ui, o2_lr, o2_li} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h required=0", {ov2, o2_ur, o2_ui, o2_lr, o2_li});
        end
        #1;
        rst_n = 1'b1;
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL async_reset_pre_drain got=%0d required=0", q2.size());
        end
        for (int n = 0; n < 8; n++) begin
            if (n >= 2) q2.push_back(mk(eu[n-2], el[n-2]));
            drive(1'b0, n + 1, n + 11, n == 0);
            if (n <= 2) begin
                checks++;
                if (ov2 !== (n == 2)) begin
                    failures++;
                    $display("FAIL async_reset_refill beat=%0d got=%b required=%b", n, ov2, n == 2);
                end
            end
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL async_reset_drain got=%0d required=0", q2.size());
        end
    endtask

    task automatic test_reframe();
        int eu[6] = '{13, 2, 3, 16, 17, 6};
        int el[6] = '{11, 12, 1, 14, 15, 4};
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n >= 2) q2.push_back(mk(eu[n-2], el[n-2]));
            drive(1'b0, n + 1, n + 11, n == 0 || n == 3);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q2.size() != 0) begin
            failures++;
            $display("FAIL reframe_drain got=%0d required=0", q2.size());
        end
    endtask

    task automatic test_wide();
        int a[40];
        int b[40];
        int y1h[40];
        int k, sel, x0, y0;
        do_reset();
        mode = 1'b0;
        for (int n = 0; n < 40; n++) begin
            a[n] = (n % 3 == 0) ? -256 : ((n % 3 == 1) ? 255 : n * 7 - 100);
            b[n] = (n % 2 == 1) ? -256 : 255 - 3 * n;
            k    = n % 16;
            sel  = (k / 8) % 2;
            x0   = (n >= 8) ? a[n-8] : 0;
            y0   = (sel == 1) ? b[n] : x0;
            y1h[n] = (sel == 1) ? x0 : b[n];
            if (n >= 8) q8.push_back(mk(y0, y1h[n-8]));
            drive(1'b1, a[n], b[n], n == 0);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (q8.size() != 0) begin
            failures++;
            $display("FAIL wide_drain got=%0d required=0", q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_commutate();
        test_bypass();
        test_gap();
        test_async_reset();
        test_reframe();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
